mips_stage_mem: RTL and testbench

Memory-access stage of the pipelined MIPS core: the consumer of the execute-to-memory pipeline bundle. Each instruction is taken from `pipeExMem`. Loads and stores are issued to the data-memory port through a req/ack handshake, and the upstream stages are stalled until the access completes. Loaded data is extended, and the registered memory-to-writeback bundle `pipeMemWb` is produced.

---
 rtl/mips_stage_mem.sv | 222 ++++++++++++++++++++++
 tb/tb_mips_stage_mem.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_stage_mem.sv
// MIPS memory-access stage: req/ack data port, upstream stall, load extension.
// Optional misalignment fault: define MIPS_STAGE_MEM_ALIGN_CHECK_EN.
package mips_pkg;

    typedef struct packed {
        logic clock;
        logic reset;
    } Data_Control_Control_T;

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic [1:0] memSize;
        logic       memSigned;
    } Mips_Control_T;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } Mips_RegPorts_T;

    typedef struct packed {
        logic [31:0]    instruction;
        logic [31:0]    pcAddr;
        Mips_Control_T  control;
        logic [31:0]    regPort2;
        Mips_RegPorts_T regPorts;
        logic [31:0]    aluResult;
    } Mips_Pipeline_ExMem_T;

    typedef struct packed {
        logic [31:0]    instruction;
        logic [31:0]    pcAddr;
        Mips_Control_T  control;
        Mips_RegPorts_T regPorts;
        logic [31:0]    aluResult;
        logic [31:0]    memData;
        logic           busError;
        logic           addrError;
    } Mips_Pipeline_MemWb_T;

endpackage

module mips_stage_mem
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  Data_Control_Control_T ctrl,
    input  Mips_Pipeline_ExMem_T  pipeExMem,
    output logic                  stall,
    output logic                  memReq,
    output logic                  memWe,
    output logic [31:0]           memAddr,
    output logic [3:0]            memByteEn,
    output logic [31:0]           memWdata,
    input  logic                  memAck,
    input  logic [31:0]           memRdata,
    output Mips_Pipeline_MemWb_T  pipeMemWb
);

    localparam logic [7:0] LP_MAX = 8'(MAX_WAIT);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_cnt;
    logic [7:0]           w_cnt_nxt;
    Mips_Pipeline_ExMem_T r_req;
    logic [1:0]           r_lo;
    logic [1:0]           w_lo;
    Mips_Pipeline_MemWb_T r_wb;
    Mips_Pipeline_MemWb_T w_wb_nxt;
    logic                 w_clk;
    logic                 w_isMem;
    logic                 w_fault;
    logic                 w_issue;
    logic                 w_stall;
    logic [4:0]           w_bsh;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_ld;

    function automatic Mips_Pipeline_MemWb_T f_pass(
        input Mips_Pipeline_ExMem_T x
    );
        Mips_Pipeline_MemWb_T y;
        y             = '0;
        y.instruction = x.instruction;
        y.pcAddr      = x.pcAddr;
        y.control     = x.control;
        y.regPorts    = x.regPorts;
        y.aluResult   = x.aluResult;
        return y;
    endfunction

    assign w_clk   = ctrl.clock;
    assign w_isMem = pipeExMem.control.memRead
                   | pipeExMem.control.memWrite;

    // Low address bits after forcing half/word accesses onto their alignment.
    always_comb begin
        unique case (pipeExMem.control.memSize)
            2'd0:    w_lo = pipeExMem.aluResult[1:0];
            2'd1:    w_lo = {pipeExMem.aluResult[1], 1'b0};
            default: w_lo = 2'b00;
        endcase
    end

`ifdef MIPS_STAGE_MEM_ALIGN_CHECK_EN
    assign w_fault = w_isMem && (w_lo != pipeExMem.aluResult[1:0]);
`else
    assign w_fault = 1'b0;
`endif

    always_comb begin
        memByteEn = 4'b0000;
        memWdata  = 32'h0;
        if (r_state == S_BUSY) begin
            unique case (r_req.control.memSize)
                2'd0: begin
                    memByteEn = 4'b1000 >> r_lo;
                    memWdata  = {4{r_req.regPort2[7:0]}};
                end
                2'd1: begin
                    memByteEn = r_lo[1] ? 4'b0011 : 4'b1100;
                    memWdata  = {2{r_req.regPort2[15:0]}};
                end
                default: begin
                    memByteEn = 4'b1111;
                    memWdata  = r_req.regPort2;
                end
            endcase
        end
    end

    // Big-endian lanes: byte k sits at bits (31-8k) downto (24-8k).
    assign w_bsh  = {~r_lo, 3'b000};
    assign w_byte = memRdata[w_bsh +: 8];
    assign w_half = r_lo[1] ? memRdata[15:0] : memRdata[31:16];

    always_comb begin
        unique case (r_req.control.memSize)
            2'd0: w_ld = {{24{r_req.control.memSigned & w_byte[7]}}, w_byte};
            2'd1: w_ld = {{16{r_req.control.memSigned & w_half[15]}}, w_half};
            default: w_ld = memRdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wb_nxt    = '0;
        w_issue     = 1'b0;
        w_stall     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fault) begin
                    w_wb_nxt                  = f_pass(pipeExMem);
                    w_wb_nxt.addrError        = 1'b1;
                    w_wb_nxt.control.regWrite = 1'b0;
                end else if (w_isMem) begin
                    w_issue     = 1'b1;
                    w_stall     = 1'b1;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_BUSY;
                end else begin
                    w_wb_nxt = f_pass(pipeExMem);
                end
            end
            S_BUSY: begin
                if (memAck) begin
                    w_wb_nxt         = f_pass(r_req);
                    w_wb_nxt.memData = r_req.control.memWrite ? 32'h0 : w_ld;
                    w_cnt_nxt        = 8'd0;
                    w_state_nxt      = S_IDLE;
                end else if (r_cnt == LP_MAX) begin
                    w_wb_nxt                  = f_pass(r_req);
                    w_wb_nxt.busError         = 1'b1;
                    w_wb_nxt.control.regWrite = 1'b0;
                    w_cnt_nxt                 = 8'd0;
                    w_state_nxt               = S_IDLE;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (ctrl.reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_req   <= '0;
            r_lo    <= 2'b00;
            r_wb    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wb    <= w_wb_nxt;
            if (w_issue) begin
                r_req <= pipeExMem;
                r_lo  <= w_lo;
            end
        end
    end

    assign stall     = w_stall & ~ctrl.reset;
    assign memReq    = (r_state == S_BUSY);
    assign memWe     = memReq & r_req.control.memWrite;
    assign memAddr   = memReq ? {r_req.aluResult[31:2], 2'b00} : 32'h0;
    assign pipeMemWb = r_wb;

endmodule

// File: tb/tb_mips_stage_mem.sv
// Scoreboard bench for mips_stage_mem with MAX_WAIT = 4.
// Results queued at issue, popped when a non-bubble pipeMemWb appears.
module tb_mips_stage_mem;
    import mips_pkg::*;

    localparam int MW = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    Data_Control_Control_T ctrl;
    Mips_Pipeline_ExMem_T  pipeExMem;
    logic                  stall;
    logic                  memReq;
    logic                  memWe;
    logic [31:0]           memAddr;
    logic [3:0]            memByteEn;
    logic [31:0]           memWdata;
    logic                  memAck;
    logic [31:0]           memRdata;
    Mips_Pipeline_MemWb_T  pipeMemWb;

    Mips_Pipeline_MemWb_T  sb[$];
    int                    n_chk = 0;
    int                    n_fail = 0;

    assign ctrl = '{clock: clk, reset: rst};
    always #5 clk = ~clk;

    mips_stage_mem #(.MAX_WAIT(MW)) dut (
        .ctrl      (ctrl),
        .pipeExMem (pipeExMem),
        .stall     (stall),
        .memReq    (memReq),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memByteEn (memByteEn),
        .memWdata  (memWdata),
        .memAck    (memAck),
        .memRdata  (memRdata),
        .pipeMemWb (pipeMemWb)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic Mips_Pipeline_ExMem_T mk_op(
        input logic [31:0] ins, input logic [31:0] pc,
        input logic [31:0] addr, input logic [31:0] data,
        input logic rd, input logic wr, input logic [1:0] sz,
        input logic sg, input logic rw
    );
        Mips_Pipeline_ExMem_T o;
        o                   = '0;
        o.instruction       = ins;
        o.pcAddr            = pc;
        o.aluResult         = addr;
        o.regPort2          = data;
        o.control.memRead   = rd;
        o.control.memWrite  = wr;
        o.control.memSize   = sz;
        o.control.memSigned = sg;
        o.control.regWrite  = rw;
        o.regPorts.rs       = ins[25:21];
        o.regPorts.rt       = ins[20:16];
        o.regPorts.rd       = ins[15:11];
        return o;
    endfunction

    function automatic Mips_Pipeline_MemWb_T mk_wb(
        input Mips_Pipeline_ExMem_T o, input logic [31:0] md,
        input logic be, input logic ae
    );
        Mips_Pipeline_MemWb_T w;
        w             = '0;
        w.instruction = o.instruction;
        w.pcAddr      = o.pcAddr;
        w.control     = o.control;
        w.regPorts    = o.regPorts;
        w.aluResult   = o.aluResult;
        w.memData     = md;
        w.busError    = be;
        w.addrError   = ae;
        if (be || ae) w.control.regWrite = 1'b0;
        return w;
    endfunction

    always @(negedge clk) begin
        Mips_Pipeline_MemWb_T e;
        if (!rst && pipeMemWb != '0) begin
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wb_instr", pipeMemWb.instruction, e.instruction);
                chk("wb_pc", pipeMemWb.pcAddr, e.pcAddr);
                chk("wb_alu", pipeMemWb.aluResult, e.aluResult);
                chk("wb_memData", pipeMemWb.memData, e.memData);
                chk("wb_ctl_err",
                    32'({pipeMemWb.control, pipeMemWb.regPorts,
                         pipeMemWb.busError, pipeMemWb.addrError}),
                    32'({e.control, e.regPorts, e.busError, e.addrError}));
            end
        end
    end

    task automatic alu_op(input Mips_Pipeline_ExMem_T op);
        pipeExMem = op;
        sb.push_back(mk_wb(op, 32'h0, 1'b0, 1'b0));
        #1;
        chk("alu_stall", stall, 1'b0);
        @(posedge clk); #1;
        chk("alu_req", memReq, 1'b0);
        pipeExMem = '0;
    endtask

    task automatic mem_op(
        input string tag, input Mips_Pipeline_ExMem_T op,
        input int ack_at, input logic [31:0] rdata,
        input Mips_Pipeline_MemWb_T exp, input logic [31:0] e_addr,
        input logic [3:0] e_be, input logic [31:0] e_wd, input int e_st
    );
        int   n_st;
        logic done;
        n_st      = 0;
        done      = 1'b0;
        pipeExMem = op;
        sb.push_back(exp);
        #1;
        chk({tag, "_req_idle"}, memReq, 1'b0);
        if (stall) n_st++;
        @(posedge clk); #1;
        for (int i = 0; i <= MW && !done; i++) begin
            chk({tag, "_req"}, memReq, 1'b1);
            chk({tag, "_addr"}, memAddr, e_addr);
            chk({tag, "_be"}, memByteEn, e_be);
            chk({tag, "_we"}, memWe, op.control.memWrite);
            if (op.control.memWrite) chk({tag, "_wdata"}, memWdata, e_wd);
            chk({tag, "_bubble"}, 32'(pipeMemWb != '0), 32'd0);
            if (i == ack_at) begin
                memAck   = 1'b1;
                memRdata = rdata;
            end
            #1;
            if (stall) n_st++;
            if (memAck || i == MW) done = 1'b1;
            @(posedge clk); #1;
            memAck   = 1'b0;
            memRdata = 32'h0;
        end
        pipeExMem = '0;
        chk({tag, "_stall_cycles"}, 32'(n_st), 32'(e_st));
        chk({tag, "_req_done"}, memReq, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Mips_Pipeline_ExMem_T op;
        pipeExMem = '0;
        memAck    = 1'b0;
        memRdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_req", memReq, 1'b0);
        chk("reset_stall", stall, 1'b0);
        chk("reset_wb", 32'(pipeMemWb != '0), 32'd0);

        alu_op(mk_op(32'h012A4020, 32'h100, 32'hDEAD0000, 32'h0,
                     0, 0, 2'd2, 0, 1));

        op = mk_op(32'h80A20003, 32'h200, 32'h1003, 32'h0, 1, 0, 2'd0, 1, 1);
        mem_op("lb", op, 0, 32'h112233F4, mk_wb(op, 32'hFFFFFFF4, 0, 0),
               32'h1000, 4'b0001, 32'h0, 1);

        op = mk_op(32'h90A20003, 32'h204, 32'h1003, 32'h0, 1, 0, 2'd0, 0, 1);
        mem_op("lbu", op, 0, 32'h112233F4, mk_wb(op, 32'h000000F4, 0, 0),
               32'h1000, 4'b0001, 32'h0, 1);

        op = mk_op(32'hA4A20002, 32'h208, 32'h2002, 32'hAAAA1234,
                   0, 1, 2'd1, 0, 0);
        mem_op("sh", op, 1, 32'hFFFFFFFF, mk_wb(op, 32'h0, 0, 0),
               32'h2000, 4'b0011, 32'h12341234, 2);

        op = mk_op(32'h8CA40000, 32'h20C, 32'h4000, 32'h0, 1, 0, 2'd2, 0, 1);
        mem_op("lw_wait3", op, 3, 32'hCAFEBABE,
               mk_wb(op, 32'hCAFEBABE, 0, 0), 32'h4000, 4'b1111, 32'h0, 4);

        op = mk_op(32'h94A60002, 32'h210, 32'h5002, 32'h0, 1, 0, 2'd1, 0, 1);
        mem_op("lhu", op, 0, 32'h1234F00D, mk_wb(op, 32'h0000F00D, 0, 0),
               32'h5000, 4'b0011, 32'h0, 1);

        op = mk_op(32'h84A60000, 32'h214, 32'h5000, 32'h0, 1, 0, 2'd1, 1, 1);
        mem_op("lh", op, 0, 32'h80017777, mk_wb(op, 32'hFFFF8001, 0, 0),
               32'h5000, 4'b1100, 32'h0, 1);

        op = mk_op(32'hA0A70001, 32'h218, 32'h6001, 32'h1234565A,
                   0, 1, 2'd0, 0, 0);
        mem_op("sb", op, 0, 32'h0, mk_wb(op, 32'h0, 0, 0),
               32'h6000, 4'b0100, 32'h5A5A5A5A, 1);

        op = mk_op(32'h80A80002, 32'h21C, 32'h6002, 32'h0, 1, 0, 2'd0, 1, 1);
        mem_op("lb_lane2", op, 0, 32'h00007F00, mk_wb(op, 32'h0000007F, 0, 0),
               32'h6000, 4'b0010, 32'h0, 1);

        op = mk_op(32'h8CA90000, 32'h220, 32'h7000, 32'h0, 1, 0, 2'd2, 0, 1);
        mem_op("timeout", op, -1, 32'h0, mk_wb(op, 32'h0, 1, 0),
               32'h7000, 4'b1111, 32'h0, 5);

        op = mk_op(32'h8CAA0004, 32'h224, 32'h7004, 32'h0, 1, 0, 2'd2, 0, 1);
        mem_op("ack_at_limit", op, MW, 32'h13579BDF,
               mk_wb(op, 32'h13579BDF, 0, 0), 32'h7004, 4'b1111, 32'h0, 5);

        op = mk_op(32'h8CAB0001, 32'h228, 32'h3001, 32'h0, 1, 0, 2'd2, 0, 1);
`ifdef MIPS_STAGE_MEM_ALIGN_CHECK_EN
        pipeExMem = op;
        sb.push_back(mk_wb(op, 32'h0, 0, 1));
        #1;
        chk("mis_stall", stall, 1'b0);
        @(posedge clk); #1;
        chk("mis_req", memReq, 1'b0);
        pipeExMem = '0;
`else
        mem_op("lw_mis", op, 0, 32'h0BADF00D, mk_wb(op, 32'h0BADF00D, 0, 0),
               32'h3000, 4'b1111, 32'h0, 1);
`endif

        op = mk_op(32'h8CAC0000, 32'h22C, 32'h8000, 32'h0, 1, 0, 2'd2, 0, 1);
        pipeExMem = op;
        @(posedge clk); #1;
        chk("rst_busy_req", memReq, 1'b1);
        rst       = 1'b1;
        memAck    = 1'b1;
        memRdata  = 32'h55555555;
        pipeExMem = '0;
        @(posedge clk); #1;
        chk("rst_req", memReq, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_wb", 32'(pipeMemWb != '0), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ack_ignored_req", memReq, 1'b0);
        chk("rst_ack_ignored_wb", pipeMemWb.memData, 32'h0);
        memAck   = 1'b0;
        memRdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
